fft_11_input_collector: RTL and testbench
=========================================

FFT_11_INPUT_COLLECTOR -- requirements
Module: fft_11_input_collector

Interface
REQ-001 Parameter WL, default 9: signed word length of each real and imaginary input component.
REQ-002 Parameter N_PT, default 11: points per frame; fixed at 11; any other value is a compile-time error.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: serial sample present.
REQ-007 Port in_sof, input, 1: start of frame; qualified by in_valid.
REQ-008 Port in_r / in_i, input, WL each: signed serial sample.
REQ-009 Port in_ready, output, 1: block accepts a sample this cycle.
REQ-010 Port load, output, 1: one-cycle strobe; parallel frame valid. Drives the FFT stage's load input.
REQ-011 Ports x0_r..x10_r and x0_i..x10_i, output, WL each: signed parallel frame. x0 is the earliest sample.
REQ-012 Port sync_err, output, 1: sticky framing-error flag.
REQ-013 Port frame_cnt, output, 16: count of emitted frames.
REQ-014 Port clear_err, input, 1: synchronous clear of sync_err.

Function
REQ-015 Accept rule: a sample is accepted when in_valid and in_ready are both 1 at a rising edge of clk.
REQ-016 in_ready SHALL be 1 in every cycle after reset release; no backpressure is applied.
REQ-017 FSM states: IDLE and FILL, with a 4-bit index idx in the range 0..10.
- IDLE: a sample accepted with in_sof=1 goes to staging slot 0; set idx=1; go to FILL.
- IDLE: a sample accepted with in_sof=0 is discarded; set sync_err.
REQ-018 FILL, accepted sample with in_sof=0: store it in slot idx; increment idx.
REQ-019 FILL, accepted sample at idx=10: SHALL complete the frame.
- Copy all staging slots, including this sample, to the x* output registers.
- Assert load in the next cycle only.
- Increment frame_cnt.
- Return to IDLE with idx=0.
REQ-020 Latency: load and the new x* values SHALL appear 1 cycle after the edge that accepts the 11th sample.
REQ-021 FILL, accepted sample with in_sof=1 (early SOF):
- Discard the partial frame.
- Set sync_err.
- Store the sample as slot 0; set idx=1; remain in FILL.
- Do not assert load.
REQ-022 in_valid=0 in FILL SHALL hold idx and the staging slots; gaps of any length are allowed.
REQ-023 x* outputs SHALL hold the last completed frame until the next completion; load is 0 otherwise.
REQ-024 Back-to-back operation: an SOF accepted in the same cycle that load is high SHALL start the next frame normally. The minimum spacing between load pulses is 11 cycles.
REQ-025 frame_cnt SHALL wrap from 65535 to 0.
REQ-026 clear_err=1 SHALL clear sync_err at the next edge. If a new error occurs in the same cycle, the error takes priority and sync_err stays 1.
REQ-027 No arithmetic is performed on samples; they are stored bit-exact with sign preserved.

Reset
REQ-028 While reset=0, the following SHALL hold:
- FSM in IDLE, idx=0.
- load=0, in_ready=0.
- All x* outputs 0, all staging slots 0.
- sync_err=0, frame_cnt=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; no load pulse follows reset release.

Structure
REQ-030 A shared package SHALL hold N_PT=11, the FSM state type and the frame_cnt width. The FFT stage and the bench reuse the same package.
REQ-031 One sub-module, fft_11_sample_slot, SHALL be instantiated 11 times. It is a WL-pair register with write-enable and async active-low reset.

Verification
REQ-032 Reset release followed by 11 contiguous samples (in_sof on the first, values k+1 / -(k+1) for k=0..10):
- Exactly one load pulse, 1 cycle after the 11th accept.
- x0_r=1, x0_i=-1, x10_r=11, x10_i=-11.
- frame_cnt=1.
REQ-033 Frame delivered with random in_valid gaps -> identical x* result and a single load pulse.
REQ-034 in_sof reasserted at sample 5 of a frame, followed by 10 more samples:
- sync_err=1.
- One load pulse only, carrying the second frame's data in x0..x10.
REQ-035 Samples with no SOF after reset -> no load pulse; sync_err=1. Then clear_err=1 -> sync_err=0 on the next edge.
REQ-036 127 back-to-back frames from the FFT-stage pattern set (WL=9):
- 127 load pulses, each exactly 11 cycles apart.
- frame_cnt=127.
- Parallel outputs match the corresponding pattern rows.
REQ-037 Reset asserted after 6 samples, then released, then one full frame:
- No load pulse for the partial frame.
- The following full frame completes correctly with frame_cnt=1.

Source files
------------

// File: rtl/fft_11_input_collector_pkg.sv
// Shared constants and types for the 11-point FFT front end.
// The collector, the FFT stage and the bench all import this package.
package fft_11_input_collector_pkg;

  localparam int FFT_N_PT    = 11;
  localparam int IDX_W       = 4;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/fft_11_sample_slot.sv
// One complex staging slot: a WL-bit real/imaginary register pair with write enable.
module fft_11_sample_slot
  import fft_11_input_collector_pkg::*;
#(
  parameter int WL = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic signed [WL-1:0] i_r,
  input  logic signed [WL-1:0] i_i,
  output logic signed [WL-1:0] o_r,
  output logic signed [WL-1:0] o_i
);

  logic signed [WL-1:0] r_r;
  logic signed [WL-1:0] r_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r <= '0;
      r_i <= '0;
    end else if (i_we) begin
      r_r <= i_r;
      r_i <= i_i;
    end
  end

  assign o_r = r_r;
  assign o_i = r_i;

endmodule

// File: rtl/fft_11_input_collector.sv
// Serial-to-parallel collector: gathers 11 complex samples framed by in_sof
// and presents them to the FFT stage with a one-cycle load strobe.
module fft_11_input_collector
  import fft_11_input_collector_pkg::*;
#(
  parameter int WL   = 9,
  parameter int N_PT = FFT_N_PT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic signed [WL-1:0]   in_r,
  input  logic signed [WL-1:0]   in_i,
  input  logic                   clear_err,
  output logic                   in_ready,
  output logic                   load,
  output logic signed [WL-1:0]   x0_r,  x1_r, x2_r, x3_r, x4_r, x5_r,
  output logic signed [WL-1:0]   x6_r,  x7_r, x8_r, x9_r, x10_r,
  output logic signed [WL-1:0]   x0_i,  x1_i, x2_i, x3_i, x4_i, x5_i,
  output logic signed [WL-1:0]   x6_i,  x7_i, x8_i, x9_i, x10_i,
  output logic                   sync_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  if (N_PT != FFT_N_PT) begin : g_bad_npt
    $error("fft_11_input_collector: N_PT must be 11");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N_PT - 1);

  state_t                 r_state;
  state_t                 w_nextState;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_nextIdx;
  logic                   w_accept;
  logic                   w_complete;
  logic                   w_errSet;
  logic [FFT_N_PT-1:0]    w_slotWe;
  logic signed [WL-1:0]   w_slotR [FFT_N_PT];
  logic signed [WL-1:0]   w_slotI [FFT_N_PT];
  logic signed [WL-1:0]   r_xR    [FFT_N_PT];
  logic signed [WL-1:0]   r_xI    [FFT_N_PT];
  logic                   r_load;
  logic                   r_syncErr;
  logic [FRAME_CNT_W-1:0] r_frameCnt;

  // No backpressure: ready simply follows reset release.
  assign in_ready = reset;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_nextState;
      r_idx   <= w_nextIdx;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_slotWe    = '0;
    w_complete  = 1'b0;
    w_errSet    = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (in_sof) begin
            w_slotWe[0] = 1'b1;
            w_nextIdx   = IDX_W'(1);
            w_nextState = ST_FILL;
          end else begin
            w_errSet = 1'b1;
          end
        end
        ST_FILL: begin
          if (in_sof) begin
            // Early SOF restarts the frame; the partial data is simply overwritten.
            w_errSet    = 1'b1;
            w_slotWe[0] = 1'b1;
            w_nextIdx   = IDX_W'(1);
          end else begin
            for (int k = 0; k < FFT_N_PT; k++) begin
              w_slotWe[k] = (r_idx == IDX_W'(k));
            end
            if (r_idx == LAST_IDX) begin
              w_complete  = 1'b1;
              w_nextIdx   = '0;
              w_nextState = ST_IDLE;
            end else begin
              w_nextIdx = r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          w_nextState = ST_IDLE;
          w_nextIdx   = '0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < FFT_N_PT; k++) begin : g_slot
    fft_11_sample_slot #(.WL(WL)) u_slot (
      .clk   (clk),
      .reset (reset),
      .i_we  (w_slotWe[k]),
      .i_r   (in_r),
      .i_i   (in_i),
      .o_r   (w_slotR[k]),
      .o_i   (w_slotI[k])
    );
  end

  // The completing sample bypasses its slot so the frame lands in one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < FFT_N_PT; k++) begin
        r_xR[k] <= '0;
        r_xI[k] <= '0;
      end
      r_load     <= 1'b0;
      r_syncErr  <= 1'b0;
      r_frameCnt <= '0;
    end else begin
      r_load <= w_complete;
      if (w_complete) begin
        for (int k = 0; k < FFT_N_PT; k++) begin
          r_xR[k] <= w_slotWe[k] ? in_r : w_slotR[k];
          r_xI[k] <= w_slotWe[k] ? in_i : w_slotI[k];
        end
        r_frameCnt <= r_frameCnt + FRAME_CNT_W'(1);
      end
      if (w_errSet) begin
        r_syncErr <= 1'b1;
      end else if (clear_err) begin
        r_syncErr <= 1'b0;
      end
    end
  end

  assign load      = r_load;
  assign sync_err  = r_syncErr;
  assign frame_cnt = r_frameCnt;

  assign x0_r  = r_xR[0];
  assign x1_r  = r_xR[1];
  assign x2_r  = r_xR[2];
  assign x3_r  = r_xR[3];
  assign x4_r  = r_xR[4];
  assign x5_r  = r_xR[5];
  assign x6_r  = r_xR[6];
  assign x7_r  = r_xR[7];
  assign x8_r  = r_xR[8];
  assign x9_r  = r_xR[9];
  assign x10_r = r_xR[10];
  assign x0_i  = r_xI[0];
  assign x1_i  = r_xI[1];
  assign x2_i  = r_xI[2];
  assign x3_i  = r_xI[3];
  assign x4_i  = r_xI[4];
  assign x5_i  = r_xI[5];
  assign x6_i  = r_xI[6];
  assign x7_i  = r_xI[7];
  assign x8_i  = r_xI[8];
  assign x9_i  = r_xI[9];
  assign x10_i = r_xI[10];

endmodule

// File: tb/tb_fft_11_input_collector.sv
// Self-checking bench for fft_11_input_collector: table-driven single-cycle
// vectors plus directed multi-cycle sequences (gaps, early SOF, reset, back-to-back).
module tb_fft_11_input_collector;
  import fft_11_input_collector_pkg::*;

  localparam int WL = 9;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_sof;
  logic signed [WL-1:0]   in_r;
  logic signed [WL-1:0]   in_i;
  logic                   clear_err;
  logic                   in_ready;
  logic                   load;
  logic signed [WL-1:0]   x_r [FFT_N_PT];
  logic signed [WL-1:0]   x_i [FFT_N_PT];
  logic                   sync_err;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  typedef struct {
    bit valid;
    bit sof;
    int r;
    int i;
    bit clear;
    bit expLoad;
    bit expErr;
    int expX10r;
  } vec_t;

  vec_t vecs[$];
  int   expR [FFT_N_PT];
  int   expI [FFT_N_PT];
  int   totalCnt = 0;
  int   badCnt = 0;
  int   cycleCnt = 0;
  int   loadCount = 0;
  int   lastLoadCycle = -1;
  bit   spacingOn = 1'b0;
  int   loadBefore;

  fft_11_input_collector #(.WL(WL), .N_PT(11)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_r      (in_r),
    .in_i      (in_i),
    .clear_err (clear_err),
    .in_ready  (in_ready),
    .load      (load),
    .x0_r (x_r[0]),  .x1_r (x_r[1]),  .x2_r (x_r[2]),  .x3_r (x_r[3]),
    .x4_r (x_r[4]),  .x5_r (x_r[5]),  .x6_r (x_r[6]),  .x7_r (x_r[7]),
    .x8_r (x_r[8]),  .x9_r (x_r[9]),  .x10_r(x_r[10]),
    .x0_i (x_i[0]),  .x1_i (x_i[1]),  .x2_i (x_i[2]),  .x3_i (x_i[3]),
    .x4_i (x_i[4]),  .x5_i (x_i[5]),  .x6_i (x_i[6]),  .x7_i (x_i[7]),
    .x8_i (x_i[8]),  .x9_i (x_i[9]),  .x10_i(x_i[10]),
    .sync_err  (sync_err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
    totalCnt++;
    if (act !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Load pulses are counted mid-cycle; spacing is checked during the back-to-back run.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      if (spacingOn && lastLoadCycle >= 0)
        checkOutput("load spacing", cycleCnt - lastLoadCycle, 11);
      lastLoadCycle = cycleCnt;
      loadCount++;
    end
  end

  task automatic applyStimulus(input bit v, input bit s, input int r, input int im,
                               input bit clr);
    in_valid  = v;
    in_sof    = s;
    in_r      = WL'(r);
    in_i      = WL'(im);
    clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input int gapMax);
    for (int k = 0; k < FFT_N_PT; k++) begin
      repeat ($urandom_range(0, gapMax)) applyStimulus(1'b0, 1'b1, 99, -99, 1'b0);
      applyStimulus(1'b1, k == 0, expR[k], expI[k], 1'b0);
    end
  endtask

  task automatic checkFrame(input string tag);
    for (int k = 0; k < FFT_N_PT; k++) begin
      checkOutput($sformatf("%s x%0d_r", tag, k), x_r[k], expR[k]);
      checkOutput($sformatf("%s x%0d_i", tag, k), x_i[k], expI[k]);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " in_ready"}, in_ready, 0);
    checkOutput({tag, " load"}, load, 0);
    checkOutput({tag, " sync_err"}, sync_err, 0);
    checkOutput({tag, " frame_cnt"}, frame_cnt, 0);
    checkOutput({tag, " x0_r"}, x_r[0], 0);
    checkOutput({tag, " x10_i"}, x_i[10], 0);
  endtask

  function automatic int patR(int f, int k);
    return ((f * 11 + k) * 37 + 5) % 512 - 256;
  endfunction

  function automatic int patI(int f, int k);
    return ((f * 11 + k) * 53 + 100) % 512 - 256;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_i = '0; clear_err = 1'b0;

    // Frame of k+1 / -(k+1), then no-SOF samples and clear_err interplay.
    for (int k = 0; k < FFT_N_PT; k++)
      vecs.push_back('{1'b1, k == 0, k + 1, -(k + 1), 1'b0, k == 10, 1'b0, (k == 10) ? 11 : 0});
    vecs.push_back('{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 11});
    vecs.push_back('{1'b1, 1'b0, 5, 5, 1'b0, 1'b0, 1'b1, 11});
    vecs.push_back('{1'b1, 1'b0, 6, 6, 1'b0, 1'b0, 1'b1, 11});
    vecs.push_back('{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 11});
    vecs.push_back('{1'b1, 1'b0, 7, 7, 1'b1, 1'b0, 1'b1, 11});
    vecs.push_back('{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 11});
    vecs.push_back('{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 11});

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b1;
    #1;
    checkOutput("in_ready after release", in_ready, 1);

    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n].valid, vecs[n].sof, vecs[n].r, vecs[n].i, vecs[n].clear);
      checkOutput($sformatf("vec%0d load", n), load, vecs[n].expLoad);
      checkOutput($sformatf("vec%0d sync_err", n), sync_err, vecs[n].expErr);
      checkOutput($sformatf("vec%0d x10_r", n), x_r[10], vecs[n].expX10r);
    end
    for (int k = 0; k < FFT_N_PT; k++) begin
      expR[k] = k + 1;
      expI[k] = -(k + 1);
    end
    checkOutput("first frame load count", loadCount, 1);
    checkOutput("first frame frame_cnt", frame_cnt, 1);
    checkFrame("first frame");

    $display("[TB] frame with random in_valid gaps");
    loadBefore = loadCount;
    sendFrame(3);
    checkOutput("gap load", load, 1);
    checkFrame("gap");
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("gap load count", loadCount - loadBefore, 1);
    checkOutput("gap frame_cnt", frame_cnt, 2);
    checkOutput("gap sync_err", sync_err, 0);

    $display("[TB] early SOF at sample 5");
    loadBefore = loadCount;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, k == 0, 100 + k, -(100 + k), 1'b0);
    for (int k = 0; k < FFT_N_PT; k++) begin
      expR[k] = 20 * k - 100;
      expI[k] = 13 * k - 60;
    end
    sendFrame(0);
    checkOutput("early sof load", load, 1);
    checkFrame("early sof");
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("early sof sync_err", sync_err, 1);
    checkOutput("early sof load count", loadCount - loadBefore, 1);
    checkOutput("early sof frame_cnt", frame_cnt, 3);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("early sof cleared", sync_err, 0);
    clear_err = 1'b0;

    $display("[TB] reset after 6 samples");
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, k == 0, 200 + k, -(200 + k), 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    checkResetState("mid-frame reset");
    reset = 1'b1;
    loadBefore = loadCount;
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("post-reset no load", loadCount - loadBefore, 0);
    for (int k = 0; k < FFT_N_PT; k++) begin
      expR[k] = 30 + k;
      expI[k] = -(30 + 2 * k);
    end
    sendFrame(0);
    checkOutput("post-reset load", load, 1);
    checkFrame("post-reset");
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("post-reset load count", loadCount - loadBefore, 1);
    checkOutput("post-reset frame_cnt", frame_cnt, 1);

    $display("[TB] 127 back-to-back frames");
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    reset = 1'b1;
    loadBefore = loadCount;
    lastLoadCycle = -1;
    spacingOn = 1'b1;
    for (int f = 0; f < 127; f++) begin
      for (int k = 0; k < FFT_N_PT; k++) begin
        expR[k] = patR(f, k);
        expI[k] = patI(f, k);
      end
      sendFrame(0);
      checkOutput($sformatf("b2b f%0d load", f), load, 1);
      checkFrame($sformatf("b2b f%0d", f));
    end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    spacingOn = 1'b0;
    checkOutput("b2b load count", loadCount - loadBefore, 127);
    checkOutput("b2b frame_cnt", frame_cnt, 127);
    checkOutput("b2b sync_err", sync_err, 0);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
